// File: rtl/mem_arbiter.sv
// Two-port arbiter and access sequencer in front of a negedge-sampled memory.
// Port 0 (IFU) is read-only, port 1 (LSU) may write; one access in flight at a time.
`timescale 1ns/1ps
module mem_arbiter #(
    parameter int unsigned LATENCY   = 1,
    parameter logic [31:0] IDLE_ADDR = 32'h8000_0000
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic        ifu_req_valid,
    output logic        ifu_req_ready,
    input  logic [31:0] ifu_req_addr,
    output logic        ifu_resp_valid,
    input  logic        ifu_resp_ready,
    output logic [63:0] ifu_resp_data,
    input  logic        lsu_req_valid,
    output logic        lsu_req_ready,
    input  logic [31:0] lsu_req_addr,
    input  logic        lsu_req_wen,
    input  logic [63:0] lsu_req_wdata,
    input  logic [7:0]  lsu_req_wmask,
    output logic        lsu_resp_valid,
    input  logic        lsu_resp_ready,
    output logic [63:0] lsu_resp_data,
    output logic [31:0] mem_raddr,
    input  logic [63:0] mem_rdata,
    output logic [31:0] mem_waddr,
    output logic [63:0] mem_wdata,
    output logic [7:0]  mem_wmask,
    output logic        busy
);

    localparam int unsigned        CNT_W    = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [CNT_W-1:0]   CNT_LOAD = CNT_W'(LATENCY - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    state_t           r_state;
    logic             r_last_grant;
    logic             r_port;
    logic [31:0]      r_addr;
    logic             r_wen;
    logic [63:0]      r_wdata;
    logic [7:0]       r_wmask;
    logic [CNT_W-1:0] r_cnt;
    logic [63:0]      r_resp_data;

    logic w_idle;
    logic w_access;
    logic w_grant_ifu;
    logic w_grant_lsu;
    logic w_resp_hs;

    assign w_idle   = (r_state == ST_IDLE);
    assign w_access = (r_state == ST_ACCESS);

    // On a tie the port that did not win last time is served (r_last_grant=1 means LSU).
    assign w_grant_ifu = w_idle && ifu_req_valid && (!lsu_req_valid || r_last_grant);
    assign w_grant_lsu = w_idle && lsu_req_valid && (!ifu_req_valid || !r_last_grant);

    assign w_resp_hs = (r_state == ST_RESP) && (r_port ? lsu_resp_ready : ifu_resp_ready);

    // Request latch, latency countdown and IDLE/ACCESS/RESP sequencing.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_state      <= ST_IDLE;
            r_last_grant <= 1'b1;
            r_port       <= 1'b0;
            r_addr       <= 32'h0;
            r_wen        <= 1'b0;
            r_wdata      <= 64'h0;
            r_wmask      <= 8'h0;
            r_cnt        <= '0;
            r_resp_data  <= 64'h0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_grant_ifu) begin
                        r_port       <= 1'b0;
                        r_addr       <= ifu_req_addr;
                        r_wen        <= 1'b0;
                        r_wdata      <= 64'h0;
                        r_wmask      <= 8'h0;
                        r_last_grant <= 1'b0;
                        r_cnt        <= CNT_LOAD;
                        r_state      <= ST_ACCESS;
                    end else if (w_grant_lsu) begin
                        r_port       <= 1'b1;
                        r_addr       <= lsu_req_addr;
                        r_wen        <= lsu_req_wen;
                        r_wdata      <= lsu_req_wdata;
                        r_wmask      <= lsu_req_wmask;
                        r_last_grant <= 1'b1;
                        r_cnt        <= CNT_LOAD;
                        r_state      <= ST_ACCESS;
                    end else begin
                        r_state      <= ST_IDLE;
                    end
                end
                ST_ACCESS: begin
                    if (r_cnt == '0) begin
                        r_resp_data <= mem_rdata;
                        r_state     <= ST_RESP;
                    end else begin
                        r_cnt       <= r_cnt - CNT_W'(1);
                    end
                end
                ST_RESP: begin
                    if (w_resp_hs) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_state <= ST_RESP;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign ifu_req_ready  = w_grant_ifu;
    assign lsu_req_ready  = w_grant_lsu;
    assign ifu_resp_valid = (r_state == ST_RESP) && !r_port;
    assign lsu_resp_valid = (r_state == ST_RESP) && r_port;
    assign ifu_resp_data  = r_resp_data;
    assign lsu_resp_data  = r_resp_data;

    // The mask is only exposed on the final access cycle so memory sees exactly one write.
    assign mem_raddr = w_access ? r_addr  : IDLE_ADDR;
    assign mem_waddr = w_access ? r_addr  : IDLE_ADDR;
    assign mem_wdata = w_access ? r_wdata : 64'h0;
    assign mem_wmask = (w_access && r_wen && (r_cnt == '0)) ? r_wmask : 8'h0;
    assign busy      = !w_idle;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: three instances (LATENCY 1, 2, 3), each with a
// negedge byte-masked memory model that reads before it writes.
`timescale 1ns/1ps
module tb_mem_arbiter;

    localparam int          N      = 3;
    localparam logic [31:0] IDLE_A = 32'h8000_0000;
    localparam logic [63:0] INIT0  = 64'h1122_3344_5566_7788;
    localparam logic [63:0] BEEF   = 64'hDEAD_BEEF_0000_0000;

    logic clock  = 1'b0;
    logic resetn = 1'b1;
    int   cyc    = 0;

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    logic [N-1:0]       iv, ir, irv, irr, lv, lr, lwen, lrv, lrr, busy;
    logic [N-1:0][31:0] ia, la, raddr, waddr;
    logic [N-1:0][63:0] idat, lwd, ldat, wdata;
    logic [N-1:0][7:0]  lwm, wmask;

    typedef struct {
        int          k;
        logic        port;
        logic [63:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    function automatic logic [63:0] init_word(input logic [3:0] i);
        return (i == 4'd0) ? INIT0 : 64'h0;
    endfunction

    function automatic logic [63:0] merge(input logic [63:0] old, input logic [63:0] wd,
                                          input logic [7:0] wm);
        logic [63:0] r;
        r = old;
        for (int b = 0; b < 8; b++) begin
            if (wm[b]) r[8*b +: 8] = wd[8*b +: 8];
        end
        return r;
    endfunction

    for (genvar g = 0; g < N; g++) begin : g_m
        logic [63:0] rd  = 64'h0;
        logic [63:0] mem [16];
        logic [15:0] wrt = 16'h0;
        int          wm_cnt = 0;
        int          wm_cyc = -1;

        mem_arbiter #(.LATENCY(g + 1), .IDLE_ADDR(IDLE_A)) u_dut (
            .clock(clock), .resetn(resetn),
            .ifu_req_valid(iv[g]), .ifu_req_ready(ir[g]), .ifu_req_addr(ia[g]),
            .ifu_resp_valid(irv[g]), .ifu_resp_ready(irr[g]), .ifu_resp_data(idat[g]),
            .lsu_req_valid(lv[g]), .lsu_req_ready(lr[g]), .lsu_req_addr(la[g]),
            .lsu_req_wen(lwen[g]), .lsu_req_wdata(lwd[g]), .lsu_req_wmask(lwm[g]),
            .lsu_resp_valid(lrv[g]), .lsu_resp_ready(lrr[g]), .lsu_resp_data(ldat[g]),
            .mem_raddr(raddr[g]), .mem_rdata(rd),
            .mem_waddr(waddr[g]), .mem_wdata(wdata[g]), .mem_wmask(wmask[g]),
            .busy(busy[g])
        );

        // Memory: read the old word, then apply the masked write on the same negedge.
        always @(negedge clock) begin
            rd <= wrt[raddr[g][6:3]] ? mem[raddr[g][6:3]] : init_word(raddr[g][6:3]);
            if (wmask[g] != 8'h00) begin
                mem[waddr[g][6:3]] <= merge(wrt[waddr[g][6:3]] ? mem[waddr[g][6:3]]
                                            : init_word(waddr[g][6:3]), wdata[g], wmask[g]);
                wrt[waddr[g][6:3]] <= 1'b1;
                wm_cnt <= wm_cnt + 1;
                wm_cyc <= cyc;
            end
        end
    end

    function automatic int get_wm_cnt(input int k);
        case (k)
            0:       return g_m[0].wm_cnt;
            1:       return g_m[1].wm_cnt;
            default: return g_m[2].wm_cnt;
        endcase
    endfunction

    function automatic int get_wm_cyc(input int k);
        case (k)
            0:       return g_m[0].wm_cyc;
            1:       return g_m[1].wm_cyc;
            default: return g_m[2].wm_cyc;
        endcase
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, req);
        end
    endtask

    task automatic push(input int k, input logic port, input logic [63:0] d);
        exp_t e;
        e.k = k; e.port = port; e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic sb_pop(input int k, input logic port, input logic [63:0] d, input logic other);
        exp_t e;
        if (exp_q.size() == 0) begin
            total++; bad++;
            $display("FAIL resp_unexpected: got inst=%0d port=%0d data=%h want none", k, port, d);
        end else begin
            e = exp_q.pop_front();
            check("resp_inst", 64'(k), 64'(e.k));
            check("resp_port", 64'(port), 64'(e.port));
            check("resp_data", d, e.data);
            check("resp_other_valid", 64'(other), 64'd0);
        end
    endtask

    // Monitor: any response handshake seen here completes on the next posedge.
    always @(negedge clock) begin
        for (int k = 0; k < N; k++) begin
            if (irv[k] && irr[k]) sb_pop(k, 1'b0, idat[k], lrv[k]);
            if (lrv[k] && lrr[k]) sb_pop(k, 1'b1, ldat[k], irv[k]);
        end
    end

    task automatic align();
        @(posedge clock);
        #1;
    endtask

    task automatic ifu_drive(input int k, input logic [31:0] a);
        ia[k] = a;
        iv[k] = 1'b1;
    endtask

    task automatic lsu_drive(input int k, input logic [31:0] a, input logic we,
                             input logic [63:0] wd, input logic [7:0] wm);
        la[k] = a; lwen[k] = we; lwd[k] = wd; lwm[k] = wm;
        lv[k] = 1'b1;
    endtask

    task automatic accept_wait(input int k, input logic port, output int acc);
        acc = -1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            if ((port ? lr[k] : ir[k]) == 1'b1) begin
                @(posedge clock);
                #1;
                acc = cyc;
                if (port) lv[k] = 1'b0;
                else      iv[k] = 1'b0;
                break;
            end
        end
        if (acc < 0) begin
            total++; bad++;
            $display("FAIL accept_timeout: inst=%0d port=%0d got no ready want ready", k, port);
            iv[k] = 1'b0; lv[k] = 1'b0;
        end
    endtask

    task automatic wait_resp(input int k, input logic port, output int rc);
        rc = -1;
        for (int i = 0; i < 60; i++) begin
            @(negedge clock);
            if ((port ? lrv[k] : irv[k]) == 1'b1) begin
                rc = cyc;
                break;
            end
        end
        if (rc < 0) begin
            total++; bad++;
            $display("FAIL resp_timeout: inst=%0d port=%0d got no resp_valid want resp_valid", k, port);
        end
    endtask

    task automatic wait_idle(input int k);
        int ok;
        ok = 0;
        for (int i = 0; i < 80; i++) begin
            @(negedge clock);
            if (!busy[k] && exp_q.size() == 0) begin
                ok = 1;
                break;
            end
        end
        if (ok == 0) begin
            total++; bad++;
            $display("FAIL idle_timeout: inst=%0d got busy=%0d pending=%0d want idle", k, busy[k], exp_q.size());
        end
    endtask

    int         acc, rc, w0, n;
    logic [1:0] order   [4];
    logic [1:0] exp_ord [4];

    initial begin
        iv = '0; lv = '0; ia = '0; la = '0; lwen = '0; lwd = '0; lwm = '0;
        irr = '1; lrr = '1;
        exp_ord = '{2'b01, 2'b10, 2'b01, 2'b10};
        #2 resetn = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        for (int k = 0; k < N; k++) begin
            check("rst_busy",   64'(busy[k]), 64'd0);
            check("rst_ifu_rv", 64'(irv[k]),  64'd0);
            check("rst_lsu_rv", 64'(lrv[k]),  64'd0);
            check("rst_rdata",  idat[k],      64'd0);
            check("rst_wmask",  64'(wmask[k]), 64'd0);
            check("rst_raddr",  64'(raddr[k]), 64'(IDLE_A));
            check("rst_waddr",  64'(waddr[k]), 64'(IDLE_A));
        end
        resetn = 1'b1;

        // Single fetch, LATENCY=1.
        w0 = get_wm_cnt(0);
        align();
        ifu_drive(0, 32'h8000_0000);
        push(0, 1'b0, INIT0);
        accept_wait(0, 1'b0, acc);
        wait_resp(0, 1'b0, rc);
        check("fetch_latency", 64'(rc - acc), 64'd1);
        wait_idle(0);
        check("fetch_wmask_count", 64'(get_wm_cnt(0) - w0), 64'd0);

        // LSU write returns pre-write data, then read back the merged word.
        w0 = get_wm_cnt(0);
        align();
        lsu_drive(0, 32'h8000_0010, 1'b1, BEEF, 8'hF0);
        push(0, 1'b1, 64'h0);
        accept_wait(0, 1'b1, acc);
        wait_resp(0, 1'b1, rc);
        check("write_latency", 64'(rc - acc), 64'd1);
        check("write_wmask_count", 64'(get_wm_cnt(0) - w0), 64'd1);
        check("write_wmask_cycle", 64'(get_wm_cyc(0) - acc), 64'd0);
        wait_idle(0);
        align();
        lsu_drive(0, 32'h8000_0010, 1'b0, 64'h0, 8'h00);
        push(0, 1'b1, BEEF);
        accept_wait(0, 1'b1, acc);
        wait_idle(0);

        // Contention: last grant was LSU, so the order is IFU, LSU, IFU, LSU.
        align();
        ia[0] = 32'h8000_0000; la[0] = 32'h8000_0010; lwen[0] = 1'b0; lwm[0] = 8'h00;
        iv[0] = 1'b1; lv[0] = 1'b1;
        push(0, 1'b0, INIT0); push(0, 1'b1, BEEF); push(0, 1'b0, INIT0); push(0, 1'b1, BEEF);
        n = 0;
        for (int i = 0; i < 60 && n < 4; i++) begin
            @(negedge clock);
            if (ir[0] || lr[0]) begin
                order[n] = {lr[0], ir[0]};
                n++;
            end
        end
        @(posedge clock);
        #1;
        iv[0] = 1'b0; lv[0] = 1'b0;
        check("grant_count", 64'(n), 64'd4);
        for (int i = 0; i < 4; i++) check("grant_order", 64'(order[i]), 64'(exp_ord[i]));
        wait_idle(0);

        // Back-pressure on the LSU response starves a waiting IFU request.
        align();
        lrr[0] = 1'b0;
        lsu_drive(0, 32'h8000_0010, 1'b0, 64'h0, 8'h00);
        push(0, 1'b1, BEEF);
        accept_wait(0, 1'b1, acc);
        ifu_drive(0, 32'h8000_0000);
        push(0, 1'b0, INIT0);
        wait_resp(0, 1'b1, rc);
        for (int i = 0; i < 5; i++) begin
            check("bp_lsu_data", ldat[0], BEEF);
            check("bp_ifu_ready", 64'(ir[0]), 64'd0);
            @(negedge clock);
        end
        @(posedge clock);
        #1;
        lrr[0] = 1'b1;
        accept_wait(0, 1'b0, acc);
        wait_idle(0);

        // LATENCY=3 write: one write on the third access cycle.
        w0 = get_wm_cnt(2);
        align();
        lsu_drive(2, 32'h8000_0010, 1'b1, 64'h0123_4567_89AB_CDEF, 8'h0F);
        push(2, 1'b1, 64'h0);
        accept_wait(2, 1'b1, acc);
        wait_resp(2, 1'b1, rc);
        check("lat3_latency", 64'(rc - acc), 64'd3);
        check("lat3_wmask_count", 64'(get_wm_cnt(2) - w0), 64'd1);
        check("lat3_wmask_cycle", 64'(get_wm_cyc(2) - acc), 64'd2);
        wait_idle(2);
        align();
        lsu_drive(2, 32'h8000_0010, 1'b0, 64'h0, 8'h00);
        push(2, 1'b1, 64'h0000_0000_89AB_CDEF);
        accept_wait(2, 1'b1, acc);
        wait_idle(2);

        // Reset during the final access cycle of a LATENCY=2 write.
        w0 = get_wm_cnt(1);
        align();
        lsu_drive(1, 32'h8000_0008, 1'b1, 64'hCAFE_F00D_1234_5678, 8'hFF);
        accept_wait(1, 1'b1, acc);
        @(posedge clock);
        #1;
        check("rst_pre_wmask", 64'(wmask[1]), 64'hFF);
        resetn = 1'b0;
        #1;
        check("rst_mid_wmask", 64'(wmask[1]), 64'd0);
        check("rst_mid_busy",  64'(busy[1]),  64'd0);
        check("rst_mid_raddr", 64'(raddr[1]), 64'(IDLE_A));
        for (int k = 0; k < N; k++) begin
            check("rst_mid_ifu_rv", 64'(irv[k]), 64'd0);
            check("rst_mid_lsu_rv", 64'(lrv[k]), 64'd0);
            check("rst_mid_rdata",  idat[k],     64'd0);
        end
        @(negedge clock);
        @(posedge clock);
        #2;
        check("rst_mid_no_write", 64'(get_wm_cnt(1) - w0), 64'd0);
        resetn = 1'b1;

        // First tie after reset goes to the IFU; the aborted write left memory unchanged.
        align();
        ia[1] = 32'h8000_0000; la[1] = 32'h8000_0008; lwen[1] = 1'b0; lwm[1] = 8'h00;
        iv[1] = 1'b1; lv[1] = 1'b1;
        push(1, 1'b0, INIT0);
        push(1, 1'b1, 64'h0);
        @(negedge clock);
        check("tie_ifu_ready", 64'(ir[1]), 64'd1);
        check("tie_lsu_ready", 64'(lr[1]), 64'd0);
        @(posedge clock);
        #1;
        iv[1] = 1'b0;
        accept_wait(1, 1'b1, acc);
        wait_idle(1);

        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
